mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- MEM pipeline stage for the MIPS core; successor to the pure pass-through MEM stage.
- Contains the MEM/WB pipeline register and a load/store unit that drives a req/ack data bus.
- Handles byte, halfword and word loads and stores, with sign or zero extension and alignment checking.
- Stalls upstream with a ready signal while a bus access is pending; optional bus timeout. Register and hilo writeback fields pass through with 1-cycle latency.

Parameters:
- ADDR_W, 32, data bus address width.
- REG_AW, 5, register-file address width.
- TIMEOUT_CYC, 255, maximum cycles to wait for bus_ack_i; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid_i  in  1  EX/MEM entry valid.
- in_ready_o  out  1  stage can accept; equals (state==IDLE).
- mem_op_i  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; other codes are treated as NONE.
- mem_addr_i  in  ADDR_W  effective address.
- mem_wdata_i  in  32  store source register value.
- wreg_write_i / wreg_addr_i / wreg_data_i  in  1/REG_AW/32  register writeback request.
- whilo_i / hi_i / lo_i  in  1/32/32  hilo writeback request.
- bus_req_o  out  1  bus request, held until ack.
- bus_we_o  out  1  1 for store.
- bus_be_o  out  4  byte enables.
- bus_addr_o  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- bus_wdata_o  out  32  lane-replicated store data.
- bus_ack_i  in  1  transfer done; rdata valid in the same cycle.
- bus_rdata_i  in  32  load word.
- wb_valid_o  out  1  one-cycle pulse per retired entry.
- wreg_write_o / wreg_addr_o / wreg_data_o  out  1/REG_AW/32  to WB.
- whilo_o / hi_o / lo_o  out  1/32/32  to WB.
- align_err_o  out  1  one-cycle pulse, misaligned access.
- bus_err_o  out  1  one-cycle pulse, bus timeout.

Behaviour:
- Reset: state=IDLE; all outputs 0 except in_ready_o=1; timeout counter=0.
- Accept condition: in_valid_i && in_ready_o. All inputs are latched on acceptance; upstream holds its inputs while in_ready_o=0.
- Default every cycle: wb_valid_o, wreg_write_o, whilo_o, align_err_o and bus_err_o are 0 unless set below. Data and address outputs hold their last values.
- NONE accepted in IDLE:
  - Next edge: wb_valid_o=1; wreg_* and whilo/hi/lo take the input values (write enables gated by acceptance).
  - State stays IDLE; latency is 1 cycle.
- Alignment check:
  - LH/LHU/SH: misaligned if addr[0]=1.
  - LW/SW: misaligned if addr[1:0]≠0.
- Misaligned accept: no bus access. Next edge: wb_valid_o=1, wreg_write_o=0, whilo_o=0, align_err_o=1. State stays IDLE.
- Aligned load/store accept: next edge state→BUSY. In BUSY:
  - bus_req_o=1; bus_we_o/be/addr/wdata are stable until ack.
- Byte enables (little-endian, lanes indexed by addr[1:0]):
  - byte: 4'b0001<<a.
  - half: 4'b0011<<a.
  - word: 4'b1111.
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load extraction:
  - Byte: rdata[8a+7:8a]. LB sign-extends; LBU zero-extends.
  - Half: rdata[8a+15:8a]. LH sign-extends; LHU zero-extends.
  - LW: full word.
- BUSY with bus_ack_i=1:
  - Next edge: bus_req_o=0 and state→IDLE.
  - wb_valid_o=1, with the latched wreg_write/addr and hilo fields.
  - wreg_data_o = extracted load value for loads, latched wreg_data for stores.
  - Ack-to-writeback latency is 1 cycle; minimum accept-to-retire is 2 cycles.
- Timeout counter: cleared on entering BUSY, incremented each BUSY cycle without ack.
  - If TIMEOUT_CYC>0 and the counter reaches TIMEOUT_CYC-1 with no ack: next edge bus_req_o=0, state→IDLE, wb_valid_o=1, wreg_write_o=0, whilo_o=0, bus_err_o=1.
  - An ack in that same cycle wins: normal completion, no error.
- bus_ack_i in IDLE is ignored (late ack after reset or timeout).
- rst mid-BUSY: next edge state=IDLE, bus_req_o=0, no wb_valid_o; the transaction is dropped.
- No new entry is accepted while BUSY; acceptance and completion never overlap in the same cycle.

Test Plan:
- Pass-through: accept NONE, wreg_write=1, addr=5, data=0x12345678, whilo=1, hi=0xA, lo=0xB -> next cycle wb_valid_o=1 with the same values; in_ready_o stays 1.
- LB at addr 0x103, ack after 3 cycles with rdata=0x80FF0011 -> bus_be_o=4'b1000, bus_addr_o=0x100; wreg_data_o=0xFFFFFF80 one cycle after ack. The same access as LBU gives 0x00000080.
- SH at addr 0x22, wdata=0xDEADBEEF -> bus_we_o=1, bus_be_o=4'b1100, bus_wdata_o=0xBEEFBEEF; on ack wb_valid_o=1; wreg_write_o follows the latched input.
- LW at addr 0x06 -> bus_req_o never asserted; next cycle align_err_o=1, wb_valid_o=1, wreg_write_o=0.
- TIMEOUT_CYC=4, SW with no ack -> bus_req_o high for exactly 4 cycles, then bus_err_o=1, wb_valid_o=1, wreg_write_o=0. A late ack afterwards is ignored.
- rst asserted on the 2nd BUSY cycle of an LH -> next cycle bus_req_o=0, in_ready_o=1, wb_valid_o=0. A back-to-back LW then completes normally.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: MEM/WB register plus a load/store unit on a req/ack data bus.
// Handles byte/half/word accesses, alignment checking and an optional bus timeout.
//
// state | meaning
// IDLE  | ready for a new entry; NONE and misaligned entries retire in 1 cycle
// BUSY  | bus access outstanding, bus_req_o held until ack or timeout
module mem_stage_lsu #(
    parameter int ADDR_W      = 32,
    parameter int REG_AW      = 5,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        mem_op_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    input  logic              wreg_write_i,
    input  logic [REG_AW-1:0] wreg_addr_i,
    input  logic [31:0]       wreg_data_i,
    input  logic              whilo_i,
    input  logic [31:0]       hi_i,
    input  logic [31:0]       lo_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_be_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [31:0]       bus_rdata_i,
    output logic              wb_valid_o,
    output logic              wreg_write_o,
    output logic [REG_AW-1:0] wreg_addr_o,
    output logic [31:0]       wreg_data_o,
    output logic              whilo_o,
    output logic [31:0]       hi_o,
    output logic [31:0]       lo_o,
    output logic              align_err_o,
    output logic              bus_err_o
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic TO_EN = (TIMEOUT_CYC > 0);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;

    logic [3:0]        r_op;
    logic [1:0]        r_lane;
    logic              r_is_load;
    logic              r_wreg_write;
    logic [REG_AW-1:0] r_wreg_addr;
    logic [31:0]       r_wreg_data;
    logic              r_whilo;
    logic [31:0]       r_hi;
    logic [31:0]       r_lo;

    logic              w_accept;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_is_byte;
    logic              w_is_half;
    logic              w_is_word;
    logic              w_misaligned;
    logic              w_start;
    logic              w_ack;
    logic              w_timeout;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;

    assign in_ready_o = (r_state == S_IDLE);
    assign bus_req_o  = (r_state == S_BUSY);
    assign w_accept   = in_valid_i && in_ready_o;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_is_byte  = 1'b0;
        w_is_half  = 1'b0;
        w_is_word  = 1'b0;
        case (mem_op_i)
            OP_LB, OP_LBU: begin w_is_load  = 1'b1; w_is_byte = 1'b1; end
            OP_LH, OP_LHU: begin w_is_load  = 1'b1; w_is_half = 1'b1; end
            OP_LW:         begin w_is_load  = 1'b1; w_is_word = 1'b1; end
            OP_SB:         begin w_is_store = 1'b1; w_is_byte = 1'b1; end
            OP_SH:         begin w_is_store = 1'b1; w_is_half = 1'b1; end
            OP_SW:         begin w_is_store = 1'b1; w_is_word = 1'b1; end
            default:       ;
        endcase
    end

    assign w_misaligned = (w_is_half && mem_addr_i[0]) ||
                          (w_is_word && (mem_addr_i[1:0] != 2'b00));
    assign w_start   = w_accept && (w_is_load || w_is_store) && !w_misaligned;
    assign w_ack     = (r_state == S_BUSY) && bus_ack_i;
    // An ack in the final timeout cycle takes priority over the error.
    assign w_timeout = TO_EN && (r_state == S_BUSY) && !bus_ack_i && (r_cnt == TO_LAST);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = mem_wdata_i;
        if (w_is_byte) begin
            w_be    = 4'b0001 << mem_addr_i[1:0];
            w_wdata = {4{mem_wdata_i[7:0]}};
        end else if (w_is_half) begin
            w_be    = 4'b0011 << mem_addr_i[1:0];
            w_wdata = {2{mem_wdata_i[15:0]}};
        end
    end

    always_comb begin
        w_byte = bus_rdata_i[7:0];
        case (r_lane)
            2'd1:    w_byte = bus_rdata_i[15:8];
            2'd2:    w_byte = bus_rdata_i[23:16];
            2'd3:    w_byte = bus_rdata_i[31:24];
            default: w_byte = bus_rdata_i[7:0];
        endcase
        w_half = r_lane[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (r_op)
            OP_LB:   w_load = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load = {24'd0, w_byte};
            OP_LH:   w_load = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load = {16'd0, w_half};
            default: w_load = bus_rdata_i;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
            S_BUSY:  if (w_ack || w_timeout) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_op         <= 4'd0;
            r_lane       <= 2'd0;
            r_is_load    <= 1'b0;
            r_wreg_write <= 1'b0;
            r_wreg_addr  <= '0;
            r_wreg_data  <= 32'd0;
            r_whilo      <= 1'b0;
            r_hi         <= 32'd0;
            r_lo         <= 32'd0;
            bus_we_o     <= 1'b0;
            bus_be_o     <= 4'd0;
            bus_addr_o   <= '0;
            bus_wdata_o  <= 32'd0;
            wb_valid_o   <= 1'b0;
            wreg_write_o <= 1'b0;
            wreg_addr_o  <= '0;
            wreg_data_o  <= 32'd0;
            whilo_o      <= 1'b0;
            hi_o         <= 32'd0;
            lo_o         <= 32'd0;
            align_err_o  <= 1'b0;
            bus_err_o    <= 1'b0;
        end else begin
            wb_valid_o   <= 1'b0;
            wreg_write_o <= 1'b0;
            whilo_o      <= 1'b0;
            align_err_o  <= 1'b0;
            bus_err_o    <= 1'b0;

            if ((r_state == S_BUSY) && !bus_ack_i) r_cnt <= r_cnt + 1'b1;

            if (w_accept) begin
                if (!(w_is_load || w_is_store)) begin
                    wb_valid_o   <= 1'b1;
                    wreg_write_o <= wreg_write_i;
                    wreg_addr_o  <= wreg_addr_i;
                    wreg_data_o  <= wreg_data_i;
                    whilo_o      <= whilo_i;
                    hi_o         <= hi_i;
                    lo_o         <= lo_i;
                end else if (w_misaligned) begin
                    wb_valid_o  <= 1'b1;
                    align_err_o <= 1'b1;
                end else begin
                    r_cnt        <= '0;
                    r_op         <= mem_op_i;
                    r_lane       <= mem_addr_i[1:0];
                    r_is_load    <= w_is_load;
                    r_wreg_write <= wreg_write_i;
                    r_wreg_addr  <= wreg_addr_i;
                    r_wreg_data  <= wreg_data_i;
                    r_whilo      <= whilo_i;
                    r_hi         <= hi_i;
                    r_lo         <= lo_i;
                    bus_we_o     <= w_is_store;
                    bus_be_o     <= w_be;
                    bus_addr_o   <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                    bus_wdata_o  <= w_wdata;
                end
            end

            if (w_ack) begin
                wb_valid_o   <= 1'b1;
                wreg_write_o <= r_wreg_write;
                wreg_addr_o  <= r_wreg_addr;
                wreg_data_o  <= r_is_load ? w_load : r_wreg_data;
                whilo_o      <= r_whilo;
                hi_o         <= r_hi;
                lo_o         <= r_lo;
            end else if (w_timeout) begin
                wb_valid_o <= 1'b1;
                bus_err_o  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: expected writebacks are queued at stimulus
// time and popped when the stage retires an entry.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        wreg_write_i;
    logic [4:0]  wreg_addr_i;
    logic [31:0] wreg_data_i;
    logic        whilo_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        wb_valid_o;
    logic        wreg_write_o;
    logic [4:0]  wreg_addr_o;
    logic [31:0] wreg_data_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        align_err_o;
    logic        bus_err_o;

    always #5 clk = ~clk;

    mem_stage_lsu #(.ADDR_W(32), .REG_AW(5), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .wreg_write_i(wreg_write_i), .wreg_addr_i(wreg_addr_i), .wreg_data_i(wreg_data_i),
        .whilo_i(whilo_i), .hi_i(hi_i), .lo_i(lo_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
        .wb_valid_o(wb_valid_o), .wreg_write_o(wreg_write_o), .wreg_addr_o(wreg_addr_o),
        .wreg_data_o(wreg_data_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
        .align_err_o(align_err_o), .bus_err_o(bus_err_o)
    );

    typedef struct {
        logic        ww;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        wh;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        aerr;
        logic        berr;
        logic        chk_data;
    } wb_t;

    wb_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic ww, input logic [4:0] wa, input logic [31:0] wd,
                        input logic wh, input logic [31:0] hi, input logic [31:0] lo,
                        input logic aerr, input logic berr, input logic chk_data);
        wb_t e;
        e.ww = ww; e.wa = wa; e.wd = wd; e.wh = wh; e.hi = hi; e.lo = lo;
        e.aerr = aerr; e.berr = berr; e.chk_data = chk_data;
        sb_q.push_back(e);
    endtask

    // Drive one entry for a single edge; returns at edge+1 with inputs released.
    task automatic accept(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic ww, input logic [4:0] wa, input logic [31:0] wd,
                          input logic wh, input logic [31:0] hi, input logic [31:0] lo);
        in_valid_i = 1'b1; mem_op_i = op; mem_addr_i = addr; mem_wdata_i = wdata;
        wreg_write_i = ww; wreg_addr_i = wa; wreg_data_i = wd;
        whilo_i = wh; hi_i = hi; lo_i = lo;
        step();
        in_valid_i = 1'b0;
    endtask

    task automatic ack_after(input int idle_cycles, input logic [31:0] rdata);
        repeat (idle_cycles) step();
        bus_ack_i = 1'b1; bus_rdata_i = rdata;
        step();
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    endtask

    task automatic wait_wb(input string tag, input int max_cyc);
        wb_t e;
        int n = 0;
        while (!wb_valid_o && n < max_cyc) begin
            step();
            n++;
        end
        check({tag, "_wb_valid"}, {31'd0, wb_valid_o}, 32'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_wreg_write"}, {31'd0, wreg_write_o}, {31'd0, e.ww});
            check({tag, "_whilo"}, {31'd0, whilo_o}, {31'd0, e.wh});
            check({tag, "_align_err"}, {31'd0, align_err_o}, {31'd0, e.aerr});
            check({tag, "_bus_err"}, {31'd0, bus_err_o}, {31'd0, e.berr});
            if (e.chk_data) begin
                check({tag, "_wreg_addr"}, {27'd0, wreg_addr_o}, {27'd0, e.wa});
                check({tag, "_wreg_data"}, wreg_data_o, e.wd);
                check({tag, "_hi"}, hi_o, e.hi);
                check({tag, "_lo"}, lo_o, e.lo);
            end
        end
    endtask

    initial begin
        int req_cnt;
        rst = 1'b1; in_valid_i = 1'b0; mem_op_i = 4'd0; mem_addr_i = 32'd0; mem_wdata_i = 32'd0;
        wreg_write_i = 1'b0; wreg_addr_i = 5'd0; wreg_data_i = 32'd0;
        whilo_i = 1'b0; hi_i = 32'd0; lo_i = 32'd0; bus_ack_i = 1'b0; bus_rdata_i = 32'd0;
        repeat (3) step();
        check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        check("rst_bus_req", {31'd0, bus_req_o}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        check("rst_wreg_data", wreg_data_o, 32'd0);
        check("rst_bus_be", {28'd0, bus_be_o}, 32'd0);
        rst = 1'b0;
        step();

        // Pass-through NONE
        push(1'b1, 5'd5, 32'h12345678, 1'b1, 32'hA, 32'hB, 1'b0, 1'b0, 1'b1);
        accept(4'd0, 32'h0, 32'h0, 1'b1, 5'd5, 32'h12345678, 1'b1, 32'hA, 32'hB);
        check("none_in_ready", {31'd0, in_ready_o}, 32'd1);
        check("none_bus_req", {31'd0, bus_req_o}, 32'd0);
        wait_wb("none", 0);
        step();
        check("none_pulse_end", {31'd0, wb_valid_o}, 32'd0);

        // LB at 0x103, ack on the 3rd BUSY cycle
        push(1'b1, 5'd7, 32'hFFFFFF80, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        accept(4'd1, 32'h103, 32'h0, 1'b1, 5'd7, 32'h55, 1'b0, 32'h0, 32'h0);
        check("lb_in_ready", {31'd0, in_ready_o}, 32'd0);
        check("lb_bus_req", {31'd0, bus_req_o}, 32'd1);
        check("lb_bus_we", {31'd0, bus_we_o}, 32'd0);
        check("lb_bus_be", {28'd0, bus_be_o}, 32'h8);
        check("lb_bus_addr", bus_addr_o, 32'h100);
        step();
        check("lb_wait_no_wb", {31'd0, wb_valid_o}, 32'd0);
        ack_after(1, 32'h80FF0011);
        wait_wb("lb", 0);
        check("lb_ready_after", {31'd0, in_ready_o}, 32'd1);

        // LBU same access
        push(1'b1, 5'd8, 32'h00000080, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        accept(4'd2, 32'h103, 32'h0, 1'b1, 5'd8, 32'h0, 1'b0, 32'h0, 32'h0);
        ack_after(2, 32'h80FF0011);
        wait_wb("lbu", 0);

        // SH at 0x22
        push(1'b1, 5'd3, 32'hCAFE0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        accept(4'd7, 32'h22, 32'hDEADBEEF, 1'b1, 5'd3, 32'hCAFE0000, 1'b0, 32'h0, 32'h0);
        check("sh_bus_we", {31'd0, bus_we_o}, 32'd1);
        check("sh_bus_be", {28'd0, bus_be_o}, 32'hC);
        check("sh_bus_wdata", bus_wdata_o, 32'hBEEFBEEF);
        check("sh_bus_addr", bus_addr_o, 32'h20);
        ack_after(0, 32'h0);
        wait_wb("sh", 0);

        // LH / LHU at 0x02, SB at 0x01
        push(1'b1, 5'd9, 32'hFFFF8001, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        accept(4'd3, 32'h2, 32'h0, 1'b1, 5'd9, 32'h0, 1'b0, 32'h0, 32'h0);
        check("lh_bus_be", {28'd0, bus_be_o}, 32'hC);
        ack_after(0, 32'h80011234);
        wait_wb("lh", 0);
        push(1'b1, 5'd10, 32'h00008001, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        accept(4'd4, 32'h2, 32'h0, 1'b1, 5'd10, 32'h0, 1'b0, 32'h0, 32'h0);
        ack_after(1, 32'h80011234);
        wait_wb("lhu", 0);
        push(1'b0, 5'd0, 32'h0, 1'b1, 32'h11, 32'h22, 1'b0, 1'b0, 1'b1);
        accept(4'd6, 32'h1, 32'h000000A5, 1'b0, 5'd0, 32'h0, 1'b1, 32'h11, 32'h22);
        check("sb_bus_be", {28'd0, bus_be_o}, 32'h2);
        check("sb_bus_wdata", bus_wdata_o, 32'hA5A5A5A5);
        ack_after(0, 32'h0);
        wait_wb("sb", 0);

        // Misaligned LW and SH
        push(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        accept(4'd5, 32'h6, 32'h0, 1'b1, 5'd4, 32'h1, 1'b1, 32'h2, 32'h3);
        check("lw_mis_bus_req", {31'd0, bus_req_o}, 32'd0);
        check("lw_mis_in_ready", {31'd0, in_ready_o}, 32'd1);
        wait_wb("lw_mis", 0);
        push(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        accept(4'd7, 32'h21, 32'h0, 1'b1, 5'd4, 32'h1, 1'b0, 32'h0, 32'h0);
        check("sh_mis_bus_req", {31'd0, bus_req_o}, 32'd0);
        wait_wb("sh_mis", 0);

        // SW with no ack: timeout after 4 request cycles
        push(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        accept(4'd8, 32'h40, 32'h01020304, 1'b1, 5'd6, 32'h0, 1'b1, 32'h0, 32'h0);
        check("sw_to_bus_wdata", bus_wdata_o, 32'h01020304);
        check("sw_to_bus_be", {28'd0, bus_be_o}, 32'hF);
        req_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (!bus_req_o) break;
            req_cnt++;
            step();
        end
        check("sw_to_req_cycles", req_cnt, 32'd4);
        wait_wb("sw_to", 0);
        bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFFFFFF;
        step();
        bus_ack_i = 1'b0;
        check("late_ack_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        check("late_ack_bus_req", {31'd0, bus_req_o}, 32'd0);
        check("late_ack_in_ready", {31'd0, in_ready_o}, 32'd1);

        // SW acked in the last allowed cycle: ack wins
        push(1'b1, 5'd11, 32'h0BADF00D, 1'b1, 32'h5, 32'h6, 1'b0, 1'b0, 1'b1);
        accept(4'd8, 32'h44, 32'h0, 1'b1, 5'd11, 32'h0BADF00D, 1'b1, 32'h5, 32'h6);
        ack_after(3, 32'h0);
        wait_wb("sw_edge", 0);

        // Reset on 2nd BUSY cycle of LH, then back-to-back LW
        accept(4'd3, 32'h10, 32'h0, 1'b1, 5'd12, 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        check("rstbusy_req_before", {31'd0, bus_req_o}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstbusy_bus_req", {31'd0, bus_req_o}, 32'd0);
        check("rstbusy_in_ready", {31'd0, in_ready_o}, 32'd1);
        check("rstbusy_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        push(1'b1, 5'd13, 32'h13579BDF, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        accept(4'd5, 32'h8, 32'h0, 1'b1, 5'd13, 32'h0, 1'b0, 32'h0, 32'h0);
        check("lw_bus_addr", bus_addr_o, 32'h8);
        check("lw_bus_be", {28'd0, bus_be_o}, 32'hF);
        ack_after(1, 32'h13579BDF);
        wait_wb("lw", 0);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
